// File: rtl/mips_mem_pkg.sv
// Types, constants and helpers shared by the MIPS instruction and data memories.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [31:0] NOP_WORD  = 32'h0;
    localparam int          NOP_CNT_W = 4;

    // Byte b0 sits at the lowest address, so it becomes the most significant byte.
    function automatic logic [31:0] be_pack(input logic [7:0] b0,
                                            input logic [7:0] b1,
                                            input logic [7:0] b2,
                                            input logic [7:0] b3);
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/nop_run_detector.sv
// Counts consecutive all-zero fetched words and flags the fetch that completes the run.
module nop_run_detector
    import mips_mem_pkg::*;
#(
    parameter int NOP_RUN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic valid,
    input  logic word_is_zero,
    output logic halt_hit
);

    localparam logic [NOP_CNT_W-1:0] LP_TARGET = NOP_CNT_W'(NOP_RUN);

    logic [NOP_CNT_W-1:0] r_nop_cnt;
    logic [NOP_CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_nop_cnt + NOP_CNT_W'(1);
    assign halt_hit  = valid && word_is_zero && (w_cnt_inc == LP_TARGET);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_nop_cnt <= '0;
        end else if (valid) begin
            r_nop_cnt <= word_is_zero ? w_cnt_inc : '0;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-addressed instruction store: word loads in LOAD, big-endian registered fetches in RUN.
// Optional simulation trace of every delivered fetch is enabled with INSTR_TRACE_EN.
module instr_mem_loader
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int NOP_RUN = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic              run_start,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_valid,
    output logic [31:0]       fetch_instr,
    output logic              running,
    output logic              halted,
    output logic              align_err,
    output logic              load_err,
    output logic [CNT_W-1:0]  instr_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0]        r_mem [DEPTH];
    state_t            r_state;
    state_t            w_next_state;
    logic              r_fetch_valid;
    logic [31:0]       r_fetch_instr;
    logic              r_align_err;
    logic              r_load_err;
    logic [CNT_W-1:0]  r_instr_count;

    logic              w_in_load;
    logic              w_load_ok;
    logic              w_load_misalign;
    logic              w_load_illegal;
    logic              w_fetch_acc;
    logic              w_fetch_aligned;
    logic              w_fetch_misalign;
    logic [31:0]       w_fetch_word;
    logic              w_halt_hit;

    assign w_in_load        = (r_state == ST_LOAD);
    assign w_load_ok        = w_in_load && load_en && (load_addr[1:0] == 2'b00);
    assign w_load_misalign  = w_in_load && load_en && (load_addr[1:0] != 2'b00);
    assign w_load_illegal   = !w_in_load && load_en;
    assign w_fetch_acc      = (r_state == ST_RUN) && fetch_req;
    assign w_fetch_aligned  = w_fetch_acc && (fetch_pc[1:0] == 2'b00);
    assign w_fetch_misalign = w_fetch_acc && (fetch_pc[1:0] != 2'b00);

    // Aligned words never cross the top of memory, so the low two bits can simply be replaced.
    assign w_fetch_word = be_pack(r_mem[{fetch_pc[ADDR_W-1:2], 2'b00}],
                                  r_mem[{fetch_pc[ADDR_W-1:2], 2'b01}],
                                  r_mem[{fetch_pc[ADDR_W-1:2], 2'b10}],
                                  r_mem[{fetch_pc[ADDR_W-1:2], 2'b11}]);

    nop_run_detector #(
        .NOP_RUN (NOP_RUN)
    ) u_nop_run_detector (
        .clk          (clk),
        .reset        (reset),
        .valid        (w_fetch_aligned),
        .word_is_zero (w_fetch_word == NOP_WORD),
        .halt_hit     (w_halt_hit)
    );

    // The memory has no reset so a program image survives a reset mid-RUN.
    always_ff @(posedge clk) begin
        if (w_load_ok) begin
            r_mem[{load_addr[ADDR_W-1:2], 2'b00}] <= load_data[31:24];
            r_mem[{load_addr[ADDR_W-1:2], 2'b01}] <= load_data[23:16];
            r_mem[{load_addr[ADDR_W-1:2], 2'b10}] <= load_data[15:8];
            r_mem[{load_addr[ADDR_W-1:2], 2'b11}] <= load_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_LOAD: if (run_start)  w_next_state = ST_RUN;
            ST_RUN:  if (w_halt_hit) w_next_state = ST_HALT;
            ST_HALT: w_next_state = ST_HALT;
            default: w_next_state = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_valid <= 1'b0;
            r_fetch_instr <= '0;
            r_align_err   <= 1'b0;
            r_load_err    <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_fetch_valid <= w_fetch_acc;
            if (w_fetch_acc) begin
                r_fetch_instr <= w_fetch_aligned ? w_fetch_word : NOP_WORD;
            end
            r_align_err <= r_align_err | w_load_misalign | w_fetch_misalign;
            r_load_err  <= r_load_err | w_load_illegal;
            if (w_fetch_aligned && (r_instr_count != '1)) begin
                r_instr_count <= r_instr_count + CNT_W'(1);
            end
        end
    end

    assign fetch_valid = r_fetch_valid;
    assign fetch_instr = r_fetch_instr;
    assign running     = (r_state == ST_RUN);
    assign halted      = (r_state == ST_HALT);
    assign align_err   = r_align_err;
    assign load_err    = r_load_err;
    assign instr_count = r_instr_count;

`ifdef INSTR_TRACE_EN
    logic [ADDR_W-1:0] r_trace_pc;
    logic              r_trace_halted;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_trace_pc     <= '0;
            r_trace_halted <= 1'b0;
        end else begin
            if (w_fetch_acc) begin
                r_trace_pc <= fetch_pc;
            end
            r_trace_halted <= halted;
        end
    end

    always @(posedge clk) begin
        if (r_fetch_valid) begin
            $display("%0t fetch pc=%h instr=%h count=%0d", $time, r_trace_pc, r_fetch_instr, r_instr_count);
        end
        if (halted && !r_trace_halted) begin
            $display("%0t HALT", $time);
        end
    end
`else
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed vector table, hand sequences, random vs model.
module tb_instr_mem_loader;

    localparam int ADDR_W  = 8;
    localparam int NOP_RUN = 4;
    localparam int CNT_W   = 4;
    localparam int DEPTH   = 256;
    localparam int CNT_MAX = 15;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              load_en = 1'b0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [31:0]       load_data = '0;
    logic              run_start = 1'b0;
    logic              fetch_req = 1'b0;
    logic [ADDR_W-1:0] fetch_pc = '0;
    logic              fetch_valid;
    logic [31:0]       fetch_instr;
    logic              running;
    logic              halted;
    logic              align_err;
    logic              load_err;
    logic [CNT_W-1:0]  instr_count;

    always #5 clk = ~clk;

    instr_mem_loader #(
        .ADDR_W  (ADDR_W),
        .NOP_RUN (NOP_RUN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .run_start   (run_start),
        .fetch_req   (fetch_req),
        .fetch_pc    (fetch_pc),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .running     (running),
        .halted      (halted),
        .align_err   (align_err),
        .load_err    (load_err),
        .instr_count (instr_count)
    );

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: byte image plus phase (0 load, 1 run, 2 halt) and sticky flags.
    logic [7:0]  mMem [DEPTH];
    int          mPhase = 0;
    int          mNops = 0;
    int          mCount = 0;
    bit          mAerr = 0;
    bit          mLerr = 0;
    bit          mValid = 0;
    logic [31:0] mInstr = '0;

    typedef struct {
        string       tag;
        bit          le;
        logic [7:0]  la;
        logic [31:0] ld;
        bit          rs;
        bit          fr;
        logic [7:0]  pc;
        bit          eValid;
        logic [31:0] eInstr;
        bit          eRun;
        bit          eHalt;
        bit          eAerr;
        bit          eLerr;
        int          eCount;
    } vec_t;

    vec_t vq[$];

    task automatic addVec(input string tag, input bit le, input int la, input logic [31:0] ld,
                          input bit rs, input bit fr, input int pc,
                          input bit ev, input logic [31:0] ei, input bit er, input bit eh,
                          input bit ea, input bit el, input int ec);
        vec_t v;
        v.tag = tag; v.le = le; v.la = 8'(la); v.ld = ld; v.rs = rs; v.fr = fr; v.pc = 8'(pc);
        v.eValid = ev; v.eInstr = ei; v.eRun = er; v.eHalt = eh; v.eAerr = ea; v.eLerr = el;
        v.eCount = ec;
        vq.push_back(v);
    endtask

    task automatic checkOutput(input string tag, input bit eValid, input logic [31:0] eInstr,
                               input bit eRun, input bit eHalt, input bit eAerr, input bit eLerr,
                               input int eCount);
        nChecks += 7;
        if (fetch_valid !== eValid) begin
            nFails++;
            $display("[TB] FAIL %s fetch_valid: got %0b expected %0b", tag, fetch_valid, eValid);
        end
        if (fetch_instr !== eInstr) begin
            nFails++;
            $display("[TB] FAIL %s fetch_instr: got %h expected %h", tag, fetch_instr, eInstr);
        end
        if (running !== eRun) begin
            nFails++;
            $display("[TB] FAIL %s running: got %0b expected %0b", tag, running, eRun);
        end
        if (halted !== eHalt) begin
            nFails++;
            $display("[TB] FAIL %s halted: got %0b expected %0b", tag, halted, eHalt);
        end
        if (align_err !== eAerr) begin
            nFails++;
            $display("[TB] FAIL %s align_err: got %0b expected %0b", tag, align_err, eAerr);
        end
        if (load_err !== eLerr) begin
            nFails++;
            $display("[TB] FAIL %s load_err: got %0b expected %0b", tag, load_err, eLerr);
        end
        if (instr_count !== CNT_W'(eCount)) begin
            nFails++;
            $display("[TB] FAIL %s instr_count: got %0d expected %0d", tag, instr_count, eCount);
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput(tag, mValid, mInstr, mPhase == 1, mPhase == 2, mAerr, mLerr, mCount);
    endtask

    // Drives one cycle of inputs, advances the model by the same cycle, and returns #1 after the edge.
    task automatic applyStimulus(input bit le, input logic [7:0] la, input logic [31:0] ld,
                                 input bit rs, input bit fr, input logic [7:0] pc);
        int prev;
        load_en = le; load_addr = la; load_data = ld;
        run_start = rs; fetch_req = fr; fetch_pc = pc;
        prev = mPhase;
        if (prev == 0) begin
            if (le) begin
                if (la % 4 == 0) begin
                    for (int k = 0; k < 4; k++) mMem[(int'(la) + k) % DEPTH] = ld[31 - 8*k -: 8];
                end else begin
                    mAerr = 1;
                end
            end
            if (rs) mPhase = 1;
        end else if (le) begin
            mLerr = 1;
        end
        mValid = 0;
        if (prev == 1 && fr) begin
            mValid = 1;
            if (pc % 4 != 0) begin
                mInstr = 32'h0;
                mAerr = 1;
            end else begin
                mInstr = {mMem[int'(pc)], mMem[int'(pc) + 1], mMem[int'(pc) + 2], mMem[int'(pc) + 3]};
                if (mCount < CNT_MAX) mCount++;
                if (mInstr == 32'h0) mNops++;
                else mNops = 0;
                if (mNops == NOP_RUN) mPhase = 2;
            end
        end
        @(posedge clk);
        #1;
        load_en = 0; run_start = 0; fetch_req = 0;
    endtask

    task automatic doReset();
        reset = 1'b0;
        mPhase = 0; mNops = 0; mCount = 0; mAerr = 0; mLerr = 0; mValid = 0; mInstr = '0;
        #1;
        checkOutput("reset_async", 0, 32'h0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0]  rla;
        logic [31:0] rld;
        logic [7:0]  rpc;

        @(posedge clk);
        #1;
        doReset();

        addVec("ld0",          1, 0,   32'h200a000a, 0, 0, 0,   0, 32'h0,        0, 0, 0, 0, 0);
        addVec("ld4",          1, 4,   32'h200c000b, 0, 0, 0,   0, 32'h0,        0, 0, 0, 0, 0);
        addVec("ld_mis3",      1, 3,   32'had4b0000, 0, 0, 0,   0, 32'h0,        0, 0, 1, 0, 0);
        addVec("ld252",        1, 252, 32'h8d500000, 0, 0, 0,   0, 32'h0,        0, 0, 1, 0, 0);
        addVec("start",        0, 0,   32'h0,        1, 0, 0,   0, 32'h0,        1, 0, 1, 0, 0);
        addVec("f0",           0, 0,   32'h0,        0, 1, 0,   1, 32'h200a000a, 1, 0, 1, 0, 1);
        addVec("f4",           0, 0,   32'h0,        0, 1, 4,   1, 32'h200c000b, 1, 0, 1, 0, 2);
        addVec("idle_hold",    0, 0,   32'h0,        0, 0, 0,   0, 32'h200c000b, 1, 0, 1, 0, 2);
        addVec("f6_mis",       0, 0,   32'h0,        0, 1, 6,   1, 32'h0,        1, 0, 1, 0, 2);
        addVec("ld_in_run",    1, 0,   32'hffffffff, 0, 0, 0,   0, 32'h0,        1, 0, 1, 1, 2);
        addVec("f0_intact",    0, 0,   32'h0,        0, 1, 0,   1, 32'h200a000a, 1, 0, 1, 1, 3);
        addVec("f252_last",    0, 0,   32'h0,        0, 1, 252, 1, 32'h8d500000, 1, 0, 1, 1, 4);
        addVec("start_in_run", 0, 0,   32'h0,        1, 0, 0,   0, 32'h8d500000, 1, 0, 1, 1, 4);

        foreach (vq[i]) begin
            applyStimulus(vq[i].le, vq[i].la, vq[i].ld, vq[i].rs, vq[i].fr, vq[i].pc);
            checkOutput(vq[i].tag, vq[i].eValid, vq[i].eInstr, vq[i].eRun, vq[i].eHalt,
                        vq[i].eAerr, vq[i].eLerr, vq[i].eCount);
        end

        // Reset in the middle of RUN keeps the program image.
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("after_reset", 0, 32'h0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("restart", 0, 32'h0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("refetch0", 1, 32'h200a000a, 1, 0, 0, 0, 1);

        // NOP run: an interleaved non-zero word restarts the count.
        doReset();
        applyStimulus(1, 0, 32'h11223344, 0, 0, 0);
        for (int a = 4; a <= 16; a += 4) applyStimulus(1, 8'(a), 32'h0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 4);
        checkOutput("nop_f4", 1, 32'h0, 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 8);
        checkOutput("nop_f8", 1, 32'h0, 1, 0, 0, 0, 2);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("nop_f0", 1, 32'h11223344, 1, 0, 0, 0, 3);
        applyStimulus(0, 0, 0, 0, 1, 4);
        applyStimulus(0, 0, 0, 0, 1, 8);
        applyStimulus(0, 0, 0, 0, 1, 12);
        checkOutput("nop_3rd", 1, 32'h0, 1, 0, 0, 0, 6);
        applyStimulus(0, 0, 0, 0, 1, 16);
        checkOutput("nop_halt", 1, 32'h0, 0, 1, 0, 0, 7);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("halt_ignore", 0, 32'h0, 0, 1, 0, 0, 7);
        applyStimulus(1, 0, 32'h5, 1, 0, 0);
        checkOutput("halt_load", 0, 32'h0, 0, 1, 0, 1, 7);

        // Randomized rounds against the model.
        for (int round = 0; round < 4; round++) begin
            doReset();
            for (int w = 0; w < DEPTH / 4; w++) begin
                rld = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
                applyStimulus(1, 8'(w * 4), rld, 0, 0, 0);
                checkModel("rnd_load");
            end
            applyStimulus(0, 0, 0, 1, 0, 0);
            checkModel("rnd_start");
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, 99) == 0) begin
                    doReset();
                end else begin
                    rla = 8'($urandom_range(0, 255));
                    rld = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
                    rpc = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                      : 8'($urandom_range(0, 63) * 4);
                    applyStimulus($urandom_range(0, 15) == 0, rla, rld,
                                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, rpc);
                    checkModel("rnd_step");
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
